// File: rtl/pc_pkg.sv
// pc_pkg: shared op encoding, request priority decode and default parameters for pc_reg_ras.
package pc_pkg;
    localparam int PC_WIDTH = 4;
    localparam int PC_STEP = 1;
    localparam int PC_RESET_VAL = 0;
    localparam int PC_DEPTH = 4;

    typedef enum logic [2:0] {OP_HOLD, OP_INC, OP_LOAD, OP_CALL, OP_RET, OP_CLEAR} pc_op_t;

    function automatic pc_op_t pc_decode(input logic clear, input logic ret, input logic call,
                                         input logic load, input logic inc);
        return clear ? OP_CLEAR : ret ? OP_RET : call ? OP_CALL : load ? OP_LOAD : inc ? OP_INC : OP_HOLD;
    endfunction
endpackage

// File: rtl/ras_lifo.sv
// ras_lifo: register-array return-address stack with guarded push/pop and synchronous pointer clear.
module ras_lifo #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       clear,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic [$clog2(DEPTH+1)-1:0] depth,
    output logic                       full,
    output logic                       empty
);
    localparam int PW = $clog2(DEPTH + 1);
    localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];

    assign full = depth == PW'(DEPTH);
    assign empty = depth == '0;
    assign dout = mem[AW'(depth - 1'b1)];

    // storage is never cleared; only the pointer defines what is valid
    always_ff @(posedge clk) begin
        if (clear) begin
            depth <= '0;
        end else if (pop && !empty) begin
            depth <= depth - 1'b1;
        end else if (push && !full) begin
            mem[AW'(depth)] <= din;
            depth <= depth + 1'b1;
        end
    end
endmodule

// File: rtl/pc_reg_ras.sv
// pc_reg_ras: parametrised program counter with optional return-address stack.
// The RAS, call/ret semantics and error flags are built only when PC_RAS_EN is defined.
module pc_reg_ras
    import pc_pkg::*;
#(
    parameter int WIDTH = PC_WIDTH,
    parameter int STEP = PC_STEP,
    parameter int RESET_VAL = PC_RESET_VAL,
    parameter int DEPTH = PC_DEPTH
) (
    input  logic                       clk,
    input  logic                       clear,
    input  logic [WIDTH-1:0]           data_in,
    input  logic                       load,
    input  logic                       inc,
    input  logic                       call,
    input  logic                       ret,
    output logic [WIDTH-1:0]           value,
    output logic                       wrap,
    output logic [$clog2(DEPTH+1)-1:0] ras_depth,
    output logic                       ras_full,
    output logic                       ras_empty,
    output logic                       err_ovf,
    output logic                       err_unf
);
    pc_op_t op;
    logic [WIDTH:0] sum;
    logic [WIDTH-1:0] ras_top;
    logic [WIDTH-1:0] next_value;

    assign op = pc_decode(clear, ret, call, load, inc);
    assign sum = {1'b0, value} + (WIDTH + 1)'(STEP);

`ifdef PC_RAS_EN
    localparam bit RAS_ON = 1'b1;

    ras_lifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_ras (
        .clk(clk),
        .clear(op == OP_CLEAR),
        .push(op == OP_CALL),
        .pop(op == OP_RET),
        .din(sum[WIDTH-1:0]),
        .dout(ras_top),
        .depth(ras_depth),
        .full(ras_full),
        .empty(ras_empty)
    );

    always_ff @(posedge clk) begin
        if (op == OP_CLEAR) begin
            err_ovf <= 1'b0;
            err_unf <= 1'b0;
        end else begin
            err_ovf <= err_ovf | (op == OP_CALL && ras_full);
            err_unf <= err_unf | (op == OP_RET && ras_empty);
        end
    end
`else
    localparam bit RAS_ON = 1'b0;

    // an always-empty stack turns ret into hold and leaves call as a plain jump
    assign ras_top = value;
    assign ras_depth = '0;
    assign ras_full = 1'b0;
    assign ras_empty = 1'b1;
    assign err_ovf = 1'b0;
    assign err_unf = 1'b0;
`endif

    always_comb begin
        next_value = op == OP_RET ? (ras_empty ? value : ras_top) :
                     (op == OP_CALL || op == OP_LOAD) ? data_in :
                     op == OP_INC ? sum[WIDTH-1:0] : value;
    end

    always_ff @(posedge clk) begin
        if (op == OP_CLEAR) begin
            value <= WIDTH'(RESET_VAL);
            wrap <= 1'b0;
        end else begin
            value <= next_value;
            wrap <= (op == OP_INC || (RAS_ON && op == OP_CALL)) && sum[WIDTH];
        end
    end
endmodule

// File: tb/tb_pc_reg_ras.sv
// tb_pc_reg_ras: directed scoreboard bench for pc_reg_ras (WIDTH=4, STEP=1, DEPTH=2, RESET_VAL=0).
// Expectations follow PC_RAS_EN, so the same bench covers both builds.
module tb_pc_reg_ras;
    localparam int WIDTH = 4;
    localparam int DEPTH = 2;
`ifdef PC_RAS_EN
    localparam bit RAS = 1'b1;
`else
    localparam bit RAS = 1'b0;
`endif

    typedef struct {
        logic [3:0] value;
        logic       wrap;
        logic [1:0] depth;
        logic       full;
        logic       empty;
        logic       ovf;
        logic       unf;
    } exp_t;

    logic clk = 1'b0;
    logic clear = 1'b0, load = 1'b0, inc = 1'b0, call = 1'b0, ret = 1'b0;
    logic [3:0] data_in = '0;
    logic [3:0] value;
    logic wrap, ras_full, ras_empty, err_ovf, err_unf;
    logic [1:0] ras_depth;

    int checks = 0;
    int errors = 0;

    exp_t sb[$];
    logic [3:0] m_val = '0;
    logic [3:0] m_ras[$];
    logic m_wrap = 1'b0, m_ovf = 1'b0, m_unf = 1'b0;

    pc_reg_ras #(.WIDTH(WIDTH), .STEP(1), .RESET_VAL(0), .DEPTH(DEPTH)) dut (
        .clk(clk), .clear(clear), .data_in(data_in), .load(load), .inc(inc),
        .call(call), .ret(ret), .value(value), .wrap(wrap), .ras_depth(ras_depth),
        .ras_full(ras_full), .ras_empty(ras_empty), .err_ovf(err_ovf), .err_unf(err_unf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model(input logic c, input logic r, input logic cl, input logic ld,
                         input logic i, input logic [3:0] d);
        logic [4:0] s;
        s = {1'b0, m_val} + 5'd1;
        m_wrap = 1'b0;
        if (c) begin
            m_val = '0;
            m_ras.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else if (r) begin
            if (RAS && m_ras.size() > 0) m_val = m_ras.pop_back();
            else if (RAS) m_unf = 1'b1;
        end else if (cl) begin
            if (RAS) begin
                m_wrap = s[4];
                if (m_ras.size() < DEPTH) m_ras.push_back(s[3:0]);
                else m_ovf = 1'b1;
            end
            m_val = d;
        end else if (ld) begin
            m_val = d;
        end else if (i) begin
            m_val = s[3:0];
            m_wrap = s[4];
        end
    endtask

    task automatic step(input logic c, input logic r, input logic cl, input logic ld,
                        input logic i, input logic [3:0] d);
        exp_t e;
        clear = c; ret = r; call = cl; load = ld; inc = i; data_in = d;
        model(c, r, cl, ld, i, d);
        e.value = m_val;
        e.wrap = m_wrap;
        e.depth = 2'(m_ras.size());
        e.full = m_ras.size() == DEPTH;
        e.empty = m_ras.size() == 0;
        e.ovf = m_ovf;
        e.unf = m_unf;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check("value", 8'(value), 8'(e.value));
        check("wrap", 8'(wrap), 8'(e.wrap));
        check("ras_depth", 8'(ras_depth), 8'(e.depth));
        check("ras_full", 8'(ras_full), 8'(e.full));
        check("ras_empty", 8'(ras_empty), 8'(e.empty));
        check("err_ovf", 8'(err_ovf), 8'(e.ovf));
        check("err_unf", 8'(err_unf), 8'(e.unf));
    endtask

    //            clr  ret  call load inc  data
    initial begin
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
        check("reset_value", 8'(value), 8'd0);
        for (int k = 0; k < 16; k++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0);
        check("wrap_at_zero", {4'(value), 4'(wrap)}, 8'h01);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
        for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'd9);
        check("load_beats_inc", 8'(value), 8'd9);
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'd9);
        check("clear_beats_load", 8'(value), 8'd0);
        for (int k = 0; k < 2; k++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd8);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd12);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd5);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0);
        step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'd4);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd1);
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 4'd3);
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'd7);
        for (int k = 0; k < 7; k++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
        step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'd4);
        check("ret_beats_load", 8'(value), 8'd7);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd15);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd2);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd6);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/pc_reg_ras.md
# pc_reg_ras

Parametrised program-counter register for the von Neumann CPU datapath, successor to the fixed 4-bit load/increment/clear register. It adds configurable width, reset value and step size, plus a small hardware return-address stack (RAS) so the control unit can implement call/return. It sits between the control FSM and the memory address mux, and drives the fetch address every cycle.

## Interface
- `WIDTH`, default 4: PC and data width in bits (≥ 2).
- `STEP`, default 1: increment amount per `inc`, 1 ≤ STEP < 2^WIDTH.
- `RESET_VAL`, default 0: PC value after `clear`.
- `DEPTH`, default 4: RAS entries (≥ 1); pointer width `$clog2(DEPTH+1)`.

- `clk`: in, 1. Single clock; all state updates on the rising edge.
- `clear`: in, 1. Synchronous, active-high reset.
- `data_in`: in, WIDTH. Jump/call target.
- `load`: in, 1. Jump: PC ← `data_in`.
- `inc`: in, 1. Advance: PC ← PC + STEP.
- `call`: in, 1. Push PC + STEP, then PC ← `data_in`.
- `ret`: in, 1. Pop into PC.
- `value`: out, WIDTH. Current PC, registered.
- `wrap`: out, 1. One-cycle registered pulse set when the last `inc` or `call` return-address computation carried out of WIDTH.
- `ras_depth`: out, `$clog2(DEPTH+1)`. Valid entries.
- `ras_full`: out, 1. `ras_depth == DEPTH`.
- `ras_empty`: out, 1. `ras_depth == 0`.
- `err_ovf`: out, 1. Sticky flag: `call` was issued while the RAS was full.
- `err_unf`: out, 1. Sticky flag: `ret` was issued while the RAS was empty.

## Operation
- Exactly one operation executes per cycle. Priority is `clear` > `ret` > `call` > `load` > `inc` > hold. Lower-priority requests in the same cycle are ignored, not queued.
- Arithmetic is modulo 2^WIDTH. The sum PC + STEP wraps silently, and its carry-out drives `wrap`.
- **inc**: `value` ← `value` + STEP. `wrap` is set for one cycle if the sum carried.
- **load**: `value` ← `data_in`. The RAS is unchanged.
- **call**:
  - The return address `value` + STEP is pushed, then `value` ← `data_in`.
  - If the RAS is full, the push is dropped and existing entries are kept. `err_ovf` is set. The PC still jumps.
  - `wrap` reflects the carry of the return-address computation.
- **ret**:
  - If the RAS is non-empty, `value` ← top entry and the depth decrements.
  - If empty, `value` holds and `err_unf` is set.
- **clear** forces:
  - `value` = RESET_VAL;
  - `ras_depth` = 0, `ras_empty` = 1, `ras_full` = 0;
  - `wrap` = 0, `err_ovf` = 0, `err_unf` = 0.
  - RAS storage contents are don't-care.
- The error flags are cleared only by `clear`.
- The RAS is strict LIFO: the most recent push is the first pop.

## Timing
- All outputs are registered and change only at `clk` rising edges. There is no combinational path from inputs to outputs.
- Latency is one cycle: an operation sampled at edge N is visible on `value` and the flags after edge N.
- `clear` asserted mid-sequence (for example, coincident with `call` to a full RAS) wins outright. No error is flagged.
- A call followed by a return on consecutive cycles is legal. Back-to-back calls and returns sustain one per cycle.
- Initial (pre-reset) state is undefined. Benches must apply `clear` first.

## Configuration
- `PC_RAS_EN` defined: RAS, `call`/`ret`, `ras_*`, `err_ovf` and `err_unf` are fully implemented as above.
- `PC_RAS_EN` undefined:
  - No RAS storage is built.
  - `call` behaves exactly as `load` (no push, `wrap` = 0).
  - `ret` is ignored and acts as hold, but still takes priority over lower operations.
  - The outputs are tied off: `ras_depth` = 0, `ras_empty` = 1, `ras_full` = 0, `err_ovf` = `err_unf` = 0.
  - The port list is unchanged.

## Structure
- Shared package `pc_pkg`:
  - op enum `pc_op_t` {OP_HOLD, OP_INC, OP_LOAD, OP_CALL, OP_RET, OP_CLEAR};
  - priority-decode function from the request bits to `pc_op_t`;
  - default parameter constants.
- One sub-module, `ras_lifo`:
  - parametrised WIDTH/DEPTH register-array stack;
  - push/pop with a full/empty guard and a synchronous clear of the pointer.
- The top level holds the PC register, adder, decode and sticky flags.

## Test plan
All scenarios use WIDTH=4, STEP=1, DEPTH=2, RESET_VAL=0, `PC_RAS_EN` defined.
- **Reset and wrap:** `clear`, then 16× `inc` → `value` steps 0…15 then 0; `wrap` = 1 only in the cycle `value` reads 0.
- **Priority:** `value`=3; assert `load`=1, `inc`=1, `data_in`=9 → `value`=9. Then `clear` with `load` → `value`=0.
- **Nested call/return:** at PC=2, `call` 8 → PC=8, depth 1. `call` 12 → PC=12, depth 2, `ras_full`=1. `ret` → 9. `ret` → 3, `ras_empty`=1.
- **Overflow:** depth 2 (entries 3, 9); `call` 5 → PC=5, depth stays 2, `err_ovf`=1. `ret` → 9. The flag stays set until `clear`.
- **Underflow:** empty RAS at PC=7; `ret` → PC stays 7, `err_unf`=1. Simultaneous `ret`+`load` 4 → `ret` wins, PC stays 7.
- **Macro off:** rebuild without `PC_RAS_EN`; `call` 6 at PC=1 → PC=6, `ras_depth`=0. `ret` → PC stays 6, `err_unf`=0.
